// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
package btn_pkg;

    localparam int DEF_DB_COUNT = 4;
    localparam int DEF_NUM_BTNS = 4;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_e;

    // Debounced level is high whenever the committed state is "held".
    function automatic logic state_is_held(input btn_state_e s);
        return (s == HELD) || (s == RELEASE_PEND);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, debounce FSM with agree counter, registered level and edge pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_COUNT = DEF_DB_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_in,
    input  logic sample_tick,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_COUNT);

    logic [1:0]       sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed;

    // Reset value 1 means "released" on the active-low raw input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n_in};
        end
    end

    assign pressed = ~sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_tick) begin
            case (state_q)
                RELEASED: begin
                    if (pressed) begin
                        if (DB_MAX == CNT_W'(1)) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            state_d = PRESS_PEND;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (!pressed) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_W'(1) >= DB_MAX) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        if (DB_MAX == CNT_W'(1)) begin
                            state_d   = RELEASED;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            state_d = RELEASE_PEND;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (pressed) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q + CNT_W'(1) >= DB_MAX) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = state_is_held(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: NUM_BTNS independent debounce channels plus an any-press flag.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DB_COUNT = DEF_DB_COUNT,
    parameter int NUM_BTNS = DEF_NUM_BTNS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_n_in,
    input  logic                sample_tick,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                any_press
);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        btn_channel #(
            .DB_COUNT (DB_COUNT)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_n_in    (btn_n_in[g]),
            .sample_tick (sample_tick),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner with default DB_COUNT=4, NUM_BTNS=4.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_n_in;
    logic       sample_tick;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       any_press;

    int n_checks = 0;
    int n_fail   = 0;

    btn_conditioner #(
        .DB_COUNT (4),
        .NUM_BTNS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n_in    (btn_n_in),
        .sample_tick (sample_tick),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and return on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        int bad;
        reset       = 1'b1;
        btn_n_in    = 4'hF;
        sample_tick = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release, any_press} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b any=%b, want all 0",
                     btn_level, btn_press, btn_release, any_press);
        end
        cyc(3);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if ({btn_level, btn_press, btn_release, any_press} !== 13'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_20clk: %0d cycles with nonzero outputs, want 0", bad);
        end
    endtask

    task automatic test_press_release;
        btn_n_in[0] = 1'b0;
        cyc(5);
        n_checks++;
        if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_edge5: lvl=%b prs=%b, want 0000/0000", btn_level, btn_press);
        end
        cyc(1);
        n_checks++;
        if (btn_level !== 4'b0001 || btn_press !== 4'b0001 || any_press !== 1'b1) begin
            n_fail++;
            $display("FAIL press_edge6: lvl=%b prs=%b any=%b, want 0001/0001/1",
                     btn_level, btn_press, any_press);
        end
        cyc(1);
        n_checks++;
        if (btn_level !== 4'b0001 || btn_press !== 4'b0000 || any_press !== 1'b0) begin
            n_fail++;
            $display("FAIL press_edge7: lvl=%b prs=%b any=%b, want 0001/0000/0",
                     btn_level, btn_press, any_press);
        end
        btn_n_in[0] = 1'b1;
        cyc(5);
        n_checks++;
        if (btn_level !== 4'b0001 || btn_release !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_edge5: lvl=%b rel=%b, want 0001/0000", btn_level, btn_release);
        end
        cyc(1);
        n_checks++;
        if (btn_level !== 4'b0000 || btn_release !== 4'b0001 || btn_press !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_edge6: lvl=%b rel=%b prs=%b, want 0000/0001/0000",
                     btn_level, btn_release, btn_press);
        end
        cyc(1);
        n_checks++;
        if (btn_release !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_edge7: rel=%b, want 0000", btn_release);
        end
    endtask

    task automatic test_glitch_abort;
        int pulses;
        int drops;
        btn_n_in[0] = 1'b0;
        cyc(8);
        n_checks++;
        if (btn_level[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_setup: lvl0=%b, want 1", btn_level[0]);
        end
        btn_n_in[0] = 1'b1;
        cyc(1);
        btn_n_in[0] = 1'b0;
        pulses = 0;
        drops  = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (btn_release[0] || btn_press[0]) pulses++;
            if (btn_level[0] !== 1'b1) drops++;
        end
        n_checks++;
        if (pulses !== 0 || drops !== 0) begin
            n_fail++;
            $display("FAIL glitch_abort: pulses=%0d level_drops=%0d, want 0/0", pulses, drops);
        end
        btn_n_in[0] = 1'b1;
        cyc(8);
    endtask

    task automatic test_bounce;
        int presses;
        int first;
        presses = 0;
        first   = -1;
        btn_n_in[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cyc(1);
            if (btn_press[1] === 1'b1) begin
                presses++;
                if (first < 0) first = k;
            end
            if (k == 3) btn_n_in[1] = 1'b1;
            if (k == 4) btn_n_in[1] = 1'b0;
        end
        n_checks++;
        if (presses !== 1 || first !== 10) begin
            n_fail++;
            $display("FAIL bounce: presses=%0d at edge %0d, want 1 at edge 10", presses, first);
        end
        n_checks++;
        if (btn_level[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_level: lvl1=%b, want 1", btn_level[1]);
        end
        btn_n_in[1] = 1'b1;
        cyc(8);
    endtask

    task automatic test_slow_tick;
        int presses;
        int first;
        logic lvl15;
        presses = 0;
        first   = -1;
        lvl15   = 1'bx;
        btn_n_in[2] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            sample_tick = (k % 4 == 0);
            cyc(1);
            if (btn_press[2] === 1'b1) begin
                presses++;
                if (first < 0) first = k;
            end
            if (k == 15) lvl15 = btn_level[2];
        end
        n_checks++;
        if (lvl15 !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_tick_frozen: lvl2 at edge 15=%b, want 0", lvl15);
        end
        n_checks++;
        if (presses !== 1 || first !== 16 || btn_level[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_tick_commit: presses=%0d at edge %0d lvl2=%b, want 1 at edge 16 lvl 1",
                     presses, first, btn_level[2]);
        end
        sample_tick = 1'b1;
        btn_n_in[2] = 1'b1;
        cyc(8);
    endtask

    task automatic test_simultaneous;
        btn_n_in = 4'h0;
        cyc(5);
        n_checks++;
        if (btn_press !== 4'h0 || btn_level !== 4'h0) begin
            n_fail++;
            $display("FAIL simul_edge5: prs=%b lvl=%b, want 0000/0000", btn_press, btn_level);
        end
        cyc(1);
        n_checks++;
        if (btn_press !== 4'hF || any_press !== 1'b1 || btn_level !== 4'hF) begin
            n_fail++;
            $display("FAIL simul_edge6: prs=%b any=%b lvl=%b, want 1111/1/1111",
                     btn_press, any_press, btn_level);
        end
        cyc(1);
        n_checks++;
        if (btn_press !== 4'h0 || any_press !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_edge7: prs=%b any=%b, want 0000/0", btn_press, any_press);
        end
    endtask

    task automatic test_reset_mid_held;
        int rel;
        reset = 1'b1;
        #1;
        n_checks++;
        if (btn_level !== 4'h0 || btn_release !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_held_async: lvl=%b rel=%b, want 0000/0000", btn_level, btn_release);
        end
        cyc(2);
        reset = 1'b0;
        cyc(5);
        n_checks++;
        if (btn_press !== 4'h0 || btn_level !== 4'h0 || btn_release !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_held_edge5: prs=%b lvl=%b rel=%b, want 0000/0000/0000",
                     btn_press, btn_level, btn_release);
        end
        cyc(1);
        n_checks++;
        if (btn_press !== 4'hF || btn_level !== 4'hF || any_press !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_held_edge6: prs=%b lvl=%b any=%b, want 1111/1111/1",
                     btn_press, btn_level, any_press);
        end
        cyc(1);
        n_checks++;
        if (btn_press !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_held_edge7: prs=%b, want 0000", btn_press);
        end
        // Release and reset while every channel is still in release-pending.
        btn_n_in = 4'hF;
        cyc(3);
        reset = 1'b1;
        #1;
        n_checks++;
        if (btn_level !== 4'h0 || btn_release !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_pend_async: lvl=%b rel=%b, want 0000/0000", btn_level, btn_release);
        end
        cyc(1);
        reset = 1'b0;
        rel = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (btn_release !== 4'h0 || btn_level !== 4'h0) rel++;
        end
        n_checks++;
        if (rel !== 0) begin
            n_fail++;
            $display("FAIL rst_pend_after: %0d cycles with release/level set, want 0", rel);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_glitch_abort();
        test_bounce();
        test_slow_tick();
        test_simultaneous();
        test_reset_mid_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
